uart_tx_arbiter: RTL

Packet-granular round-robin arbiter that shares the single UART transmit byte stream (`tx_data`/`tx_valid`/`tx_ready` of `uart`) among `NUM_PORTS` requesters. Each requester offers a byte packet delimited by a `last` flag. The arbiter grants one requester at a time and holds the grant until that packet's last byte is accepted. When `HEADER` is set, it prefixes each packet with a source-ID byte so the host can demultiplex. It sits between the on-chip packet sources and the `uart` instance.

---
 rtl/uart_tx_arbiter.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// ---------------------------------------------------------------------------
// uart_tx_arbiter
//
// Packet-granular round-robin arbiter that shares one UART transmit byte
// stream among NUM_PORTS packet sources. A requester keeps the grant from
// its first byte until the byte flagged by s_last is accepted. With HEADER=1
// every packet is preceded by a source-ID byte {4'hA, id} so the host can
// demultiplex the stream.
//
// Parameters
//   NUM_PORTS  number of requesters, 2..16 (id is carried in 4 bits)
//   HEADER     1 = prefix each packet with an ID byte, 0 = pass-through
//
// Ports
//   clk        system clock
//   reset_n    asynchronous active-low reset
//   s_data     requester bytes, port i on bits [8*i+7:8*i]
//   s_valid    per-port byte valid
//   s_last     per-port last-byte-of-packet flag (qualified by s_valid)
//   s_ready    per-port byte accept (combinational from m_ready in DATA)
//   m_data     byte towards uart tx_data
//   m_valid    towards uart tx_valid
//   m_ready    from uart tx_ready
//   grant      one-hot current owner, zero when idle
//   busy       high whenever a packet (header or data) is in progress
// ---------------------------------------------------------------------------
module uart_tx_arbiter #(
   parameter int NUM_PORTS = 4,
   parameter bit HEADER    = 1'b1
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [NUM_PORTS*8-1:0] s_data,
   input  logic [NUM_PORTS-1:0]   s_valid,
   input  logic [NUM_PORTS-1:0]   s_last,
   output logic [NUM_PORTS-1:0]   s_ready,
   output logic [7:0]             m_data,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [NUM_PORTS-1:0]   grant,
   output logic                   busy
);

   localparam int IDX_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

   // The header carries the port index in a nibble, so more than 16 ports
   // cannot be encoded.
   if (NUM_PORTS < 2 || NUM_PORTS > 16) begin : g_bad_num_ports
      $error("uart_tx_arbiter: NUM_PORTS must be in the range 2..16");
   end

   typedef enum logic [1:0] {
      IDLE,
      HDR,
      DATA
   } state_t;

   state_t           state;
   logic [IDX_W-1:0] rr_ptr;   // first port to consider at the next arbitration
   logic [IDX_W-1:0] owner;    // index of the granted port

   // Byte lanes of the flat input bus, for indexing by the owner register.
   logic [7:0] s_bytes [NUM_PORTS];

   for (genvar i = 0; i < NUM_PORTS; i++) begin : g_lanes
      assign s_bytes[i] = s_data[8*i +: 8];
   end

   // ------------------------------------------------------------------------
   // Round-robin pick: rotate the request vector so rr_ptr lands on bit 0,
   // take the lowest set bit, then rotate the offset back modulo NUM_PORTS.
   // ------------------------------------------------------------------------
   logic [NUM_PORTS-1:0] req_rot;
   logic [IDX_W:0]       pick_off;
   logic [IDX_W:0]       pick_sum;
   logic [IDX_W-1:0]     pick;

   always_comb begin
      // NOTE: every variable assigned in a combinational block gets a default
      // first so no path leaves it holding its old value (which would be a latch).
      req_rot  = NUM_PORTS'({s_valid, s_valid} >> rr_ptr);
      pick_off = '0;
      // Descending scan: the last hit written is the lowest rotated index.
      for (int off = NUM_PORTS - 1; off >= 0; off--) begin
         if (req_rot[off]) begin
            pick_off = (IDX_W + 1)'(off);
         end
      end
      pick_sum = {1'b0, rr_ptr} + pick_off;
      if (pick_sum >= (IDX_W + 1)'(NUM_PORTS)) begin
         pick_sum = pick_sum - (IDX_W + 1)'(NUM_PORTS);
      end
      pick = pick_sum[IDX_W-1:0];
   end

   // Pointer value after the current owner finishes its packet.
   logic [IDX_W-1:0] owner_next;
   logic             accept_last;

   assign owner_next  = (owner == IDX_W'(NUM_PORTS - 1)) ? '0 : owner + IDX_W'(1);
   assign accept_last = (state == DATA) && s_valid[owner] && m_ready && s_last[owner];

   // ------------------------------------------------------------------------
   // Control FSM. Other ports are ignored until the owner's last byte has been
   // accepted, even if the owner stalls mid-packet.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      // NOTE: registers are updated with non-blocking assignments so every
      // flop samples the pre-edge values, independent of statement order.
      if (!reset_n) begin
         state  <= IDLE;
         rr_ptr <= '0;
         owner  <= '0;
         grant  <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (|s_valid) begin
                  owner <= pick;
                  grant <= NUM_PORTS'(1) << pick;
                  state <= HEADER ? HDR : DATA;
               end
            end
            HDR: begin
               if (m_ready) begin
                  state <= DATA;
               end
            end
            DATA: begin
               if (accept_last) begin
                  rr_ptr <= owner_next;
                  grant  <= '0;
                  state  <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy = (state != IDLE);

   // ------------------------------------------------------------------------
   // Datapath. In DATA the owner's lane is wired straight through in both
   // directions so consecutive bytes of a packet flow without bubbles.
   // ------------------------------------------------------------------------
   always_comb begin
      m_valid = 1'b0;
      m_data  = 8'h00;
      s_ready = '0;
      case (state)
         HDR: begin
            m_valid = 1'b1;
            m_data  = {4'hA, 4'(owner)};
         end
         DATA: begin
            m_valid        = s_valid[owner];
            m_data         = s_bytes[owner];
            s_ready[owner] = m_ready;
         end
         default: begin
            m_valid = 1'b0;
         end
      endcase
   end

endmodule
